// File: rtl/fifo_out_pkg.sv
// Shared definitions for the output-FIFO control stage: default geometry and
// the 3-bit operation state encoding seen by the address-calculation stage.
package fifo_out_pkg;

  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned CW_DEF    = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100
  } state_t;

endpackage

// File: rtl/fifo_out_ns.sv
// Combinational next-state decode for the output-FIFO control stage.
// Decisions use the look-ahead count so back-to-back operations never overrun.
module fifo_out_ns
  import fifo_out_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic [2:0]    state,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [CW-1:0] next_data_count,
  output state_t        ns
);

  logic nfull;
  logic nempty;

  assign nfull  = (next_data_count == CW'(DEPTH));
  assign nempty = (next_data_count == '0);

  // Read wins over write; an illegal current encoding recovers to IDLE.
  always_comb begin
    ns = IDLE;
    if (state <= 3'b100) begin
      if (rd_en) begin
        ns = nempty ? RD_ERROR : READ;
      end else if (wr_en) begin
        ns = nfull ? WR_ERROR : WRITE;
      end
    end
  end

endmodule

// File: rtl/fifo_out_fsm.sv
// Output-FIFO control/state-register stage. Holds operation state, head, tail
// and count; the address-calculation stage returns next_* values every clock.
// Optional macro FIFO_OUT_ERR_CNT_EN adds saturating wr/rd error counters.
module fifo_out_fsm
  import fifo_out_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] next_head,
  input  logic [AW-1:0] next_tail,
  input  logic [CW-1:0] next_data_count,
  output logic [2:0]    state,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic [CW-1:0] data_count,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          rd_ack,
  output logic          wr_err,
`ifdef FIFO_OUT_ERR_CNT_EN
  output logic          rd_err,
  output logic [7:0]    wr_err_cnt,
  output logic [7:0]    rd_err_cnt
`else
  output logic          rd_err
`endif
);

  state_t cur_state;
  state_t ns;

  fifo_out_ns #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_ns (
    .state          (cur_state),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .next_data_count(next_data_count),
    .ns             (ns)
  );

  // State and pointer registers; pointers commit the current state's effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= IDLE;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      cur_state  <= ns;
      head       <= next_head;
      tail       <= next_tail;
      data_count <= next_data_count;
    end
  end

  assign state  = cur_state;
  assign full   = (data_count == CW'(DEPTH));
  assign empty  = (data_count == '0);
  assign wr_ack = (cur_state == WRITE);
  assign rd_ack = (cur_state == READ);
  assign wr_err = (cur_state == WR_ERROR);
  assign rd_err = (cur_state == RD_ERROR);

`ifdef FIFO_OUT_ERR_CNT_EN
  // Saturating counts of cycles spent in each error state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_cnt <= '0;
      rd_err_cnt <= '0;
    end else begin
      if (wr_err && wr_err_cnt != 8'hFF) wr_err_cnt <= wr_err_cnt + 8'd1;
      if (rd_err && rd_err_cnt != 8'hFF) rd_err_cnt <= rd_err_cnt + 8'd1;
    end
  end
`endif

endmodule
